// File: rtl/pool_window_feeder_pkg.sv
// Shared pooling constants: pixel width, window size and retired-window counter width.
// Used by the window feeder and the pooling datapath so both agree on geometry.
package pool_window_feeder_pkg;
   localparam int POOL_DATA_W  = 16;
   localparam int POOL_WIN     = 64;
   localparam int POOL_COUNT_W = 16;
   localparam int POOL_IDX_W   = $clog2(POOL_WIN);
endpackage

// File: rtl/pool_window_feeder_bank.sv
// One window of pixel storage: indexed write port, whole-window flattened read-out.
// Storage has no reset; validity is tracked by the owner's full flags.
module pool_bank
   import pool_window_feeder_pkg::*;
#(
   parameter int DATA_W = POOL_DATA_W,
   parameter int WIN    = POOL_WIN,
   parameter int IDX_W  = $clog2(WIN)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [IDX_W-1:0]      wr_idx,
   input  logic [DATA_W-1:0]     wr_data,
   output logic [WIN*DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [WIN];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= wr_data;
   end

   for (genvar k = 0; k < WIN; k++) begin : g_rd
      assign rd_data[k*DATA_W +: DATA_W] = mem[k];
   end

endmodule

// File: rtl/pool_window_feeder.sv
// Ping-pong window buffer: fills one bank pixel by pixel while the other is presented whole.
// pool_en rises one cycle after the last pixel; in_ready drops only when the write bank is still full.
module pool_window_feeder
   import pool_window_feeder_pkg::*;
#(
   parameter int DATA_W = POOL_DATA_W,
   parameter int WIN    = POOL_WIN
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_W-1:0]       in_data,
   input  logic                    flush,
   output logic                    pool_en,
   output logic [WIN*DATA_W-1:0]   win_data,
   input  logic                    win_ack,
   output logic [POOL_COUNT_W-1:0] win_count
);

   localparam int CNT_W = $clog2(WIN);

   logic [1:0]              full;
   logic                    wsel;
   logic                    rsel;
   logic [CNT_W-1:0]        cnt;
   logic [POOL_COUNT_W-1:0] win_cnt_q;
   logic [WIN*DATA_W-1:0]   bank_rd [2];

   logic accept;
   logic last;
   logic retire;

   assign in_ready  = !full[wsel];
   assign accept    = in_valid && in_ready;
   assign last      = accept && (cnt == CNT_W'(WIN - 1));
   assign retire    = pool_en && win_ack;
   assign pool_en   = full[rsel];
   assign win_data  = bank_rd[rsel];
   assign win_count = win_cnt_q;

   for (genvar b = 0; b < 2; b++) begin : g_bank
      pool_bank #(
         .DATA_W (DATA_W),
         .WIN    (WIN),
         .IDX_W  (CNT_W)
      ) u_bank (
         .clk     (clk),
         .wr_en   (accept && !flush && (wsel == 1'(b))),
         .wr_idx  (cnt),
         .wr_data (in_data),
         .rd_data (bank_rd[b])
      );
   end

   // A completion only targets an empty bank and a retire only a full one, so they never collide.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full      <= 2'b00;
         wsel      <= 1'b0;
         rsel      <= 1'b0;
         cnt       <= '0;
         win_cnt_q <= '0;
      end else if (flush) begin
         full <= 2'b00;
         wsel <= 1'b0;
         rsel <= 1'b0;
         cnt  <= '0;
      end else begin
         if (accept) cnt <= last ? '0 : cnt + 1'b1;
         if (last) begin
            full[wsel] <= 1'b1;
            wsel       <= ~wsel;
         end
         if (retire) begin
            full[rsel] <= 1'b0;
            rsel       <= ~rsel;
            win_cnt_q  <= win_cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pool_window_feeder.sv
// Directed bench for pool_window_feeder: single window, backpressure, overlap, flush, reset, wrap.
module tb_pool_window_feeder;

   localparam int DW  = 16;
   localparam int WIN = 64;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DW-1:0]     in_data = '0;
   logic              flush = 1'b0;
   logic              pool_en;
   logic [WIN*DW-1:0] win_data;
   logic              win_ack = 1'b0;
   logic [15:0]       win_count;

   int          checks = 0;
   int          failures = 0;
   logic [15:0] exp_count = 16'd0;

   pool_window_feeder #(.DATA_W(DW), .WIN(WIN)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .flush     (flush),
      .pool_en   (pool_en),
      .win_data  (win_data),
      .win_ack   (win_ack),
      .win_count (win_count)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] px(input int k);
      return win_data[k*DW +: DW];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] v);
      in_valid = 1'b1;
      in_data  = v;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic ack();
      win_ack = 1'b1;
      tick();
      win_ack = 1'b0;
      exp_count = exp_count + 16'd1;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (pool_en !== 1'b0) begin failures++; $display("FAIL reset_pool_en got=%b exp=0", pool_en); end
      checks++; if (win_count !== 16'd0) begin failures++; $display("FAIL reset_win_count got=%h exp=0000", win_count); end
      tick(); tick();
      rst = 1'b0;
      tick();
      win_ack = 1'b1;
      tick();
      win_ack = 1'b0;
      checks++; if (win_count !== 16'd0) begin failures++; $display("FAIL ack_ignored got=%h exp=0000", win_count); end
   endtask

   task automatic test_single_window();
      int bad_rdy = 0;
      for (int k = 0; k < WIN; k++) begin
         if (k == WIN - 1) begin
            checks++; if (pool_en !== 1'b0) begin failures++; $display("FAIL single_early_pool_en got=%b exp=0", pool_en); end
         end
         if (in_ready !== 1'b1) bad_rdy++;
         send(16'(k + 1));
      end
      checks++; if (bad_rdy != 0) begin failures++; $display("FAIL single_in_ready low_cycles=%0d exp=0", bad_rdy); end
      checks++; if (pool_en !== 1'b1) begin failures++; $display("FAIL single_pool_en got=%b exp=1", pool_en); end
      checks++; if (px(0) !== 16'd1) begin failures++; $display("FAIL single_px0 got=%h exp=0001", px(0)); end
      checks++; if (px(31) !== 16'd32) begin failures++; $display("FAIL single_px31 got=%h exp=0020", px(31)); end
      checks++; if (px(63) !== 16'd64) begin failures++; $display("FAIL single_px63 got=%h exp=0040", px(63)); end
      tick();
      checks++; if (px(63) !== 16'd64 || pool_en !== 1'b1) begin failures++; $display("FAIL single_hold got=%h/%b exp=0040/1", px(63), pool_en); end
      ack();
      checks++; if (pool_en !== 1'b0) begin failures++; $display("FAIL single_retire_pool_en got=%b exp=0", pool_en); end
      checks++; if (win_count !== exp_count) begin failures++; $display("FAIL single_win_count got=%h exp=%h", win_count, exp_count); end
   endtask

   task automatic test_backpressure();
      int bad_rdy = 0;
      for (int k = 0; k < 2 * WIN; k++) begin
         if (in_ready !== 1'b1) bad_rdy++;
         send(16'h0100 + 16'(k));
      end
      checks++; if (bad_rdy != 0) begin failures++; $display("FAIL bp_in_ready_fill low_cycles=%0d exp=0", bad_rdy); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_full got=%b exp=0", in_ready); end
      in_valid = 1'b1;
      in_data  = 16'hDEAD;
      tick(); tick(); tick();
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_hold got=%b exp=0", in_ready); end
      checks++; if (px(0) !== 16'h0100 || px(63) !== 16'h013F) begin failures++; $display("FAIL bp_window_a got=%h/%h exp=0100/013f", px(0), px(63)); end
      in_valid = 1'b0;
      win_ack  = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_no_lookahead got=%b exp=0", in_ready); end
      tick();
      win_ack = 1'b0;
      exp_count = exp_count + 16'd1;
      checks++; if (pool_en !== 1'b1 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_after_ack1 pool_en/in_ready got=%b/%b exp=1/1", pool_en, in_ready); end
      checks++; if (px(0) !== 16'h0140 || px(63) !== 16'h017F) begin failures++; $display("FAIL bp_window_b got=%h/%h exp=0140/017f", px(0), px(63)); end
      ack();
      checks++; if (pool_en !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b exp=0", pool_en); end
      checks++; if (win_count !== exp_count) begin failures++; $display("FAIL bp_win_count got=%h exp=%h", win_count, exp_count); end
   endtask

   task automatic test_simultaneous();
      for (int k = 0; k < WIN; k++) send(16'h0200 + 16'(k));
      for (int k = 0; k < WIN - 1; k++) send(16'h0300 + 16'(k));
      win_ack = 1'b1;
      send(16'h033F);
      win_ack = 1'b0;
      exp_count = exp_count + 16'd1;
      checks++; if (pool_en !== 1'b1) begin failures++; $display("FAIL sim_pool_en got=%b exp=1", pool_en); end
      checks++; if (px(0) !== 16'h0300 || px(63) !== 16'h033F) begin failures++; $display("FAIL sim_window_b got=%h/%h exp=0300/033f", px(0), px(63)); end
      checks++; if (win_count !== exp_count) begin failures++; $display("FAIL sim_win_count got=%h exp=%h", win_count, exp_count); end
      ack();
      checks++; if (pool_en !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL sim_drained pool_en/in_ready got=%b/%b exp=0/1", pool_en, in_ready); end
   endtask

   task automatic test_flush();
      for (int k = 0; k < 30; k++) send(16'h0400 + 16'(k));
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++; if (win_count !== exp_count) begin failures++; $display("FAIL flush_win_count got=%h exp=%h", win_count, exp_count); end
      for (int k = 0; k < WIN - 1; k++) send(16'h00AA);
      checks++; if (pool_en !== 1'b0) begin failures++; $display("FAIL flush_early_pool_en got=%b exp=0", pool_en); end
      send(16'h00AA);
      checks++; if (pool_en !== 1'b1) begin failures++; $display("FAIL flush_pool_en got=%b exp=1", pool_en); end
      checks++; if (px(0) !== 16'h00AA || px(29) !== 16'h00AA || px(30) !== 16'h00AA || px(63) !== 16'h00AA) begin
         failures++; $display("FAIL flush_window got=%h/%h/%h/%h exp=00aa", px(0), px(29), px(30), px(63));
      end
      ack();
   endtask

   task automatic test_async_reset();
      for (int k = 0; k < WIN; k++) send(16'h0500 + 16'(k));
      checks++; if (pool_en !== 1'b1) begin failures++; $display("FAIL arst_pre_pool_en got=%b exp=1", pool_en); end
      #2 rst = 1'b1;
      #1;
      checks++; if (pool_en !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL arst_async pool_en/in_ready got=%b/%b exp=0/1", pool_en, in_ready); end
      checks++; if (win_count !== 16'd0) begin failures++; $display("FAIL arst_win_count got=%h exp=0000", win_count); end
      #1 rst = 1'b0;
      exp_count = 16'd0;
      tick();
      for (int k = 0; k < 10; k++) send(16'h0550 + 16'(k));
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      tick();
      for (int k = 0; k < WIN - 1; k++) send(16'h0600 + 16'(k));
      checks++; if (pool_en !== 1'b0) begin failures++; $display("FAIL arst_mid_early got=%b exp=0", pool_en); end
      send(16'h063F);
      checks++; if (pool_en !== 1'b1 || px(0) !== 16'h0600 || px(63) !== 16'h063F) begin
         failures++; $display("FAIL arst_mid_window pool_en=%b px0=%h px63=%h exp=1/0600/063f", pool_en, px(0), px(63));
      end
      ack();
   endtask

   task automatic test_wrap();
      // Skip 65534 real windows by depositing the counter between clock edges.
      dut.win_cnt_q = 16'hFFFE;
      exp_count = 16'hFFFE;
      for (int k = 0; k < WIN; k++) send(16'h0700 + 16'(k));
      ack();
      checks++; if (win_count !== 16'hFFFF) begin failures++; $display("FAIL wrap_ffff got=%h exp=ffff", win_count); end
      for (int k = 0; k < WIN; k++) send(16'h0800 + 16'(k));
      ack();
      checks++; if (win_count !== 16'h0000) begin failures++; $display("FAIL wrap_zero got=%h exp=0000", win_count); end
   endtask

   initial begin
      test_reset();
      test_single_window();
      test_backpressure();
      test_simultaneous();
      test_flush();
      test_async_reset();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
